// File: rtl/rgb_seq_pkg.sv
// Shared types for the RGB fade sequencer: FSM states, keyframe layout, step helper.
package rgb_seq_pkg;

  localparam int unsigned KEY_VAL_W  = 8;
  localparam int unsigned KEY_HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2,
    HOLD = 2'd3
  } seq_state_t;

  // Field order matches cfg_data: red in the MSBs, hold in the LSBs.
  typedef struct packed {
    logic [KEY_VAL_W-1:0]  red;
    logic [KEY_VAL_W-1:0]  green;
    logic [KEY_VAL_W-1:0]  blue;
    logic [KEY_HOLD_W-1:0] hold;
  } keyframe_t;

  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt);
    if (cur < tgt) return cur + 32'd1;
    if (cur > tgt) return cur - 32'd1;
    return cur;
  endfunction

endpackage

// File: rtl/rgb_channel_ramp.sv
// One colour channel: value register that walks one LSB per enabled step toward its target.
module rgb_channel_ramp
  import rgb_seq_pkg::*;
#(
  parameter int unsigned VAL_WIDTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [VAL_WIDTH-1:0] i_target,
  input  logic                 i_step,
  output logic [VAL_WIDTH-1:0] o_val,
  output logic                 o_at_target,
  output logic                 o_changed
);

  logic [VAL_WIDTH-1:0] r_val;
  logic [VAL_WIDTH-1:0] r_target;
  logic [VAL_WIDTH-1:0] w_next;

  assign w_next = VAL_WIDTH'(step_toward(32'(r_val), 32'(r_target)));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_val    <= '0;
      r_target <= '0;
    end else begin
      if (i_load) r_target <= i_target;
      if (i_step) r_val    <= w_next;
    end
  end

  assign o_val       = r_val;
  assign o_at_target = (r_val == r_target);
  // Flags the step that will actually move the value on this edge.
  assign o_changed   = i_step && !o_at_target;

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Keyframe colour sequencer ramping three pwm_gen channels one LSB per PWM period.
// Define RGB_SEQ_LOOP_EN to wrap from the last keyframe back to key 0 instead of finishing.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned VAL_WIDTH     = KEY_VAL_W,
  parameter int unsigned MAX_PWM_COUNT = 1024,
  parameter int unsigned NUM_KEYS      = 8,
  parameter int unsigned HOLD_WIDTH    = KEY_HOLD_W
) (
  input  logic                            sys_clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_KEYS)-1:0]     cfg_addr,
  input  logic [3*VAL_WIDTH+HOLD_WIDTH-1:0] cfg_data,
  input  logic [$clog2(NUM_KEYS)-1:0]     cfg_last,
  input  logic                            start,
  input  logic                            stop,
  output logic [VAL_WIDTH-1:0]            red_val,
  output logic [VAL_WIDTH-1:0]            green_val,
  output logic [VAL_WIDTH-1:0]            blue_val,
  output logic                            val_update,
  output logic                            busy,
  output logic                            seq_done,
  output logic [$clog2(NUM_KEYS)-1:0]     cur_key
);

  localparam int unsigned KEY_W = $clog2(NUM_KEYS);
  localparam int unsigned CNT_W = $clog2(MAX_PWM_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PWM_COUNT - 1);

  logic [CNT_W-1:0]      r_tick_cnt;
  logic                  w_tick;
  keyframe_t             r_table [NUM_KEYS];
  keyframe_t             w_key;
  seq_state_t            r_state;
  seq_state_t            w_state_next;
  logic [KEY_W-1:0]      r_key_idx;
  logic [KEY_W-1:0]      r_last;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic                  r_val_update;
  logic                  r_seq_done;
  logic                  w_latch, w_load, w_step, w_hold_dec, w_key_inc, w_key_clr, w_done;
  logic [VAL_WIDTH-1:0]  w_tgt [3];
  logic [VAL_WIDTH-1:0]  w_val [3];
  logic [2:0]            w_at;
  logic [2:0]            w_chg;

  // Same reset and period as the pwm_gen counters so tick lands on their wrap.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                      r_tick_cnt <= '0;
    else if (r_tick_cnt == CNT_LAST) r_tick_cnt <= '0;
    else                          r_tick_cnt <= r_tick_cnt + CNT_W'(1);
  end
  assign w_tick = (r_tick_cnt == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (cfg_we) r_table[cfg_addr] <= keyframe_t'(cfg_data);
  end
  assign w_key = r_table[r_key_idx];

  assign w_tgt[0] = VAL_WIDTH'(w_key.red);
  assign w_tgt[1] = VAL_WIDTH'(w_key.green);
  assign w_tgt[2] = VAL_WIDTH'(w_key.blue);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      rgb_channel_ramp #(.VAL_WIDTH(VAL_WIDTH)) u_ramp (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_target    (w_tgt[gi]),
        .i_step      (w_step),
        .o_val       (w_val[gi]),
        .o_at_target (w_at[gi]),
        .o_changed   (w_chg[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_hold_dec   = 1'b0;
    w_key_inc    = 1'b0;
    w_key_clr    = 1'b0;
    w_done       = 1'b0;
    if (stop) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          w_latch      = 1'b1;
          w_state_next = LOAD;
        end
        LOAD: begin
          w_load       = 1'b1;
          w_state_next = RAMP;
        end
        RAMP: if (w_tick) begin
          if (&w_at) w_state_next = HOLD;
          else       w_step       = 1'b1;
        end
        HOLD: if (w_tick) begin
          if (r_hold_cnt != '0) begin
            w_hold_dec = 1'b1;
          end else if (r_key_idx != r_last) begin
            w_key_inc    = 1'b1;
            w_state_next = LOAD;
          end else begin
`ifdef RGB_SEQ_LOOP_EN
            w_key_clr    = 1'b1;
            w_state_next = LOAD;
`else
            w_done       = 1'b1;
            w_state_next = IDLE;
`endif
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_key_idx    <= '0;
      r_last       <= '0;
      r_hold_cnt   <= '0;
      r_val_update <= 1'b0;
      r_seq_done   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_val_update <= |w_chg;
      r_seq_done   <= w_done;
      if (w_latch) begin
        r_last    <= cfg_last;
        r_key_idx <= '0;
      end else if (w_key_inc) begin
        r_key_idx <= r_key_idx + KEY_W'(1);
      end else if (w_key_clr) begin
        r_key_idx <= '0;
      end
      if (w_load)          r_hold_cnt <= HOLD_WIDTH'(w_key.hold);
      else if (w_hold_dec) r_hold_cnt <= r_hold_cnt - HOLD_WIDTH'(1);
    end
  end

  assign red_val    = w_val[0];
  assign green_val  = w_val[1];
  assign blue_val   = w_val[2];
  assign val_update = r_val_update;
  assign busy       = (r_state != IDLE);
  assign seq_done   = r_seq_done;
  assign cur_key    = r_key_idx;

endmodule
